// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage; returns {remainder, quotient}.
// Optional macro DIV_BYZERO_EN: a zero divisor short-cuts to a zero result in two cycles.
module div_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     rem_q, rem_d;
    logic [DATA_W-1:0]     quo_q, quo_d;
    logic [DATA_W-1:0]     dvsr_q, dvsr_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    logic [DATA_W:0]       rem_shl;
    logic [DATA_W:0]       diff;
    logic [DATA_W-1:0]     quo_fix;
    logic [DATA_W-1:0]     rem_fix;
    logic                  div_zero;
    logic                  a_neg;
    logic                  b_neg;

    // Next-state, datapath and output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        rem_shl  = {rem_q, quo_q[DATA_W-1]};
        diff     = rem_shl - {1'b0, dvsr_q};
        quo_fix  = neg_quo_q ? -quo_q : quo_q;
        rem_fix  = neg_rem_q ? -rem_q : rem_q;
        div_zero = (opdata2_i == '0);
        a_neg    = signed_div_i & opdata1_i[DATA_W-1];
        b_neg    = signed_div_i & opdata2_i[DATA_W-1];

        unique case (state_q)
            S_FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
`ifdef DIV_BYZERO_EN
                    if (div_zero) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d = S_ON;
                    end
`else
                    state_d = S_ON;
`endif
                    // Magnitudes only; signs are restored after the last iteration
                    quo_d     = a_neg ? -opdata1_i : opdata1_i;
                    dvsr_d    = b_neg ? -opdata2_i : opdata2_i;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                end
            end
            S_BYZERO: begin
                rem_d     = '0;
                quo_d     = '0;
                neg_quo_d = 1'b0;
                neg_rem_d = 1'b0;
                state_d   = S_END;
            end
            S_ON: begin
                if (annul_i) begin
                    state_d = S_FREE;
                end else begin
                    if (!diff[DATA_W]) begin
                        rem_d = diff[DATA_W-1:0];
                    end else begin
                        rem_d = rem_shl[DATA_W-1:0];
                    end
                    quo_d = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = S_END;
                    end
                end
            end
            S_END: begin
                // First END cycle always pulses ready, even if start already dropped
                if (!ready_q) begin
                    ready_d  = 1'b1;
                    result_d = {rem_fix, quo_fix};
                end else if (!start_i) begin
                    ready_d  = 1'b0;
                    result_d = '0;
                    state_d  = S_FREE;
                end
            end
            default: begin
                state_d = S_FREE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, zero divisor, annul, reset.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int checks;
    int errors;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, measure edges to ready, check result, hold and release
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res,
                           input logic hold, input logic scramble);
        int lat;
        lat = -1;
        @(negedge clk);
        signed_div = sgn;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                lat = k;
                break;
            end
            if (scramble) begin
                op1 = $urandom;
                op2 = $urandom;
            end
            if (!hold && k == 3) start = 1'b0;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, result, exp_res);
        if (hold) begin
            @(posedge clk);
            #1;
            check({tag, " held ready"}, 64'(ready), 64'd1);
            check({tag, " held result"}, result, exp_res);
            start = 1'b0;
        end
        @(posedge clk);
        #1;
        check({tag, " free ready"}, 64'(ready), 64'd0);
        check({tag, " free result"}, result, 64'd0);
    endtask

    initial begin
        logic seen;
        int   zlat;
        logic [63:0] zres;

        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        signed_div = 1'b0;
        op1        = '0;
        op2        = '0;
        start      = 1'b0;
        annul      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset ready", 64'(ready), 64'd0);
        check("reset result", result, 64'd0);

        run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14}, 1'b1, 1'b0);
        run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1, 1'b0);
        run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'd1, 32'hFFFF_FFFD}, 1'b1, 1'b0);
        run_div("div -100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 33, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b1, 1'b0);
        run_div("divu big", 1'b0, 32'hFFFF_FFFF, 32'h0001_0000, 33, {32'h0000_FFFF, 32'h0000_FFFF}, 1'b1, 1'b0);
        run_div("start drop", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14}, 1'b0, 1'b0);

`ifdef DIV_BYZERO_EN
        zlat = 2;
        zres = 64'd0;
`else
        zlat = 33;
        zres = {32'd100, 32'hFFFF_FFFF};
`endif
        run_div("divu 100/0", 1'b0, 32'd100, 32'd0, zlat, zres, 1'b1, 1'b0);

        // Annul mid-division: ready must never rise
        @(negedge clk);
        signed_div = 1'b0;
        op1        = 32'hFFFF_FFFF;
        op2        = 32'd1;
        start      = 1'b1;
        seen       = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            seen |= ready;
        end
        annul = 1'b1;
        @(posedge clk);
        #1;
        seen |= ready;
        annul = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            seen |= ready;
        end
        check("annul no ready", 64'(seen), 64'd0);
        check("annul result", result, 64'd0);
        run_div("after annul 9/3", 1'b0, 32'd9, 32'd3, 33, {32'd0, 32'd3}, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a division
        @(negedge clk);
        signed_div = 1'b0;
        op1        = 32'd100;
        op2        = 32'd7;
        start      = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midreset ready", 64'(ready), 64'd0);
        check("midreset result", result, 64'd0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        run_div("after reset 9/3", 1'b0, 32'd9, 32'd3, 33, {32'd0, 32'd3}, 1'b1, 1'b0);

        run_div("div corner scrambled", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33,
                {32'd0, 32'h8000_0000}, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
